nf_wb_unit: RTL and testbench

//  Writeback stage in front of the register file.
//  - Merges completed ALU results and returning load data onto the single register-file write port (wa3/wd3/we3).
//  - Tracks one outstanding load: destination register, size, sign and byte offset.
//  - Sign- or zero-extends the returned load data.
//  - Stalls the ALU path on port collision or write-after-write hazard.

---
 rtl/nf_wb_pkg.sv | 15 +
 rtl/nf_ld_ext.sv | 27 ++
 rtl/nf_wb_unit.sv | 122 ++++++++++++
 tb/tb_nf_wb_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf_wb_pkg.sv
// Shared types for the writeback stage and the load-data extender.
package nf_wb_pkg;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2
    } ld_size_t;

    typedef enum logic {
        WB_IDLE,
        WB_LD_WAIT
    } wb_st_t;

endpackage

// File: rtl/nf_ld_ext.sv
// Load data aligner/extender: selects the addressed byte/half of a memory word
// and sign- or zero-extends it to 32 bits.
module nf_ld_ext
    import nf_wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  ld_size_t    size,
    input  logic        uns,
    input  logic [1:0]  off,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*off +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        ext      = rdata;
        case (size)
            LD_B:    ext = {{24{~uns & byte_sel[7]}}, byte_sel};
            LD_H:    ext = {{16{~uns & half_sel[15]}}, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/nf_wb_unit.sv
// Writeback stage: merges ALU results and one outstanding load onto the
// single register-file write port, with load-over-ALU priority and WAW stall.
module nf_wb_unit
    import nf_wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            alu_vld,
    input  logic [RA_W-1:0] alu_wa,
    input  logic [XLEN-1:0] alu_wd,
    output logic            alu_stall,
    input  logic            ld_req,
    output logic            ld_req_rdy,
    input  logic [RA_W-1:0] ld_wa,
    input  logic [1:0]      ld_size,
    input  logic            ld_uns,
    input  logic [1:0]      ld_off,
    input  logic            ld_rvalid,
    input  logic [XLEN-1:0] ld_rdata,
    output logic            ld_busy,
    output logic            ld_unexp,
    output logic [RA_W-1:0] wa3,
    output logic [XLEN-1:0] wd3,
    output logic            we3
);

    wb_st_t          state, state_nx;
    logic [RA_W-1:0] tag_wa;
    ld_size_t        tag_size;
    logic            tag_uns;
    logic [1:0]      tag_off;
    logic            capture;
    logic            ld_wr;
    logic            alu_wr;
    logic            unexp_nx;
    logic [XLEN-1:0] ld_ext;

    nf_ld_ext u_ld_ext (
        .rdata (ld_rdata),
        .size  (tag_size),
        .uns   (tag_uns),
        .off   (tag_off),
        .ext   (ld_ext)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= WB_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        capture    = 1'b0;
        ld_wr      = 1'b0;
        alu_stall  = 1'b0;
        unexp_nx   = 1'b0;
        ld_req_rdy = 1'b0;
        ld_busy    = 1'b0;
        case (state)
            WB_IDLE: begin
                ld_req_rdy = 1'b1;
                unexp_nx   = ld_rvalid;
                if (ld_req) begin
                    capture  = 1'b1;
                    state_nx = WB_LD_WAIT;
                end
            end
            WB_LD_WAIT: begin
                ld_busy = 1'b1;
                // load data wins the port; matching non-x0 dest must also wait (WAW)
                alu_stall = alu_vld &&
                            (ld_rvalid || (alu_wa == tag_wa && alu_wa != '0));
                if (ld_rvalid) begin
                    ld_wr    = 1'b1;
                    state_nx = WB_IDLE;
                end
            end
            default: state_nx = WB_IDLE;
        endcase
        alu_wr = alu_vld && !alu_stall;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_wa   <= '0;
            tag_size <= LD_B;
            tag_uns  <= 1'b0;
            tag_off  <= '0;
        end else if (capture) begin
            tag_wa   <= ld_wa;
            tag_size <= ld_size_t'(ld_size);
            tag_uns  <= ld_uns;
            tag_off  <= ld_off;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wa3      <= '0;
            wd3      <= '0;
            we3      <= 1'b0;
            ld_unexp <= 1'b0;
        end else begin
            ld_unexp <= unexp_nx;
            if (ld_wr) begin
                wa3 <= tag_wa;
                wd3 <= ld_ext;
                we3 <= (tag_wa != '0);
            end else if (alu_wr) begin
                wa3 <= alu_wa;
                wd3 <= alu_wd;
                we3 <= (alu_wa != '0);
            end else begin
                we3 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nf_wb_unit.sv
// Self-checking bench for nf_wb_unit: directed extension table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_nf_wb_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        alu_vld;
    logic [4:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        alu_stall;
    logic        ld_req;
    logic        ld_req_rdy;
    logic [4:0]  ld_wa;
    logic [1:0]  ld_size;
    logic        ld_uns;
    logic [1:0]  ld_off;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        ld_busy;
    logic        ld_unexp;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        we3;

    int checks   = 0;
    int failures = 0;

    nf_wb_unit #(.XLEN(32), .RA_W(5)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .alu_vld    (alu_vld),
        .alu_wa     (alu_wa),
        .alu_wd     (alu_wd),
        .alu_stall  (alu_stall),
        .ld_req     (ld_req),
        .ld_req_rdy (ld_req_rdy),
        .ld_wa      (ld_wa),
        .ld_size    (ld_size),
        .ld_uns     (ld_uns),
        .ld_off     (ld_off),
        .ld_rvalid  (ld_rvalid),
        .ld_rdata   (ld_rdata),
        .ld_busy    (ld_busy),
        .ld_unexp   (ld_unexp),
        .wa3        (wa3),
        .wd3        (wd3),
        .we3        (we3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ext_vec_t;

    ext_vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_vld   = 1'b0;
        alu_wa    = '0;
        alu_wd    = '0;
        ld_req    = 1'b0;
        ld_wa     = '0;
        ld_size   = 2'd0;
        ld_uns    = 1'b0;
        ld_off    = '0;
        ld_rvalid = 1'b0;
        ld_rdata  = '0;
    endtask

    // Reference extension: plain shift/modulo arithmetic on the raw word.
    function automatic logic [31:0] m_ext(input int sz, input bit uns, input int off,
                                          input logic [31:0] d);
        longint v;
        int     bits;
        int     sh;
        if (sz != 0 && sz != 1) return d;
        bits = (sz == 0) ? 8 : 16;
        sh   = (sz == 0) ? 8 * off : 16 * (off / 2);
        v    = longint'(d >> sh) % (longint'(1) << bits);
        if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    // Model state: the one outstanding load, if any.
    bit          m_busy;
    logic [4:0]  m_wa;
    int          m_size;
    bit          m_uns;
    int          m_off;

    initial begin
        bit          e_stall, e_we, e_unexp;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;

        vecs[0] = '{2'd0, 1'b0, 2'd3, 32'h80FF_FF12, 32'hFFFF_FF80};
        vecs[1] = '{2'd0, 1'b1, 2'd3, 32'h80FF_FF12, 32'h0000_0080};
        vecs[2] = '{2'd0, 1'b0, 2'd0, 32'h80FF_FF12, 32'h0000_0012};
        vecs[3] = '{2'd0, 1'b0, 2'd1, 32'h1234_8A56, 32'hFFFF_FF8A};
        vecs[4] = '{2'd1, 1'b0, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001};
        vecs[5] = '{2'd1, 1'b1, 2'd3, 32'h8001_7FFF, 32'h0000_8001};
        vecs[6] = '{2'd1, 1'b0, 2'd1, 32'h8001_7FFF, 32'h0000_7FFF};
        vecs[7] = '{2'd2, 1'b0, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[8] = '{2'd2, 1'b1, 2'd0, 32'h8000_0000, 32'h8000_0000};
        vecs[9] = '{2'd0, 1'b1, 2'd2, 32'h00AB_0000, 32'h0000_00AB};

        clear_inputs();
        resetn = 1'b0;
        #12;
        chk("rst_we3", {31'd0, we3}, 32'd0);
        chk("rst_wa3", {27'd0, wa3}, 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_unexp", {31'd0, ld_unexp}, 32'd0);
        chk("rst_busy", {31'd0, ld_busy}, 32'd0);
        chk("rst_rdy", {31'd0, ld_req_rdy}, 32'd1);
        resetn = 1'b1;
        tick();

        // ALU-only write
        alu_vld = 1'b1; alu_wa = 5'd5; alu_wd = 32'hDEAD_BEEF;
        #1 chk("alu_stall", {31'd0, alu_stall}, 32'd0);
        tick();
        clear_inputs();
        chk("alu_we3", {31'd0, we3}, 32'd1);
        chk("alu_wa3", {27'd0, wa3}, 32'd5);
        chk("alu_wd3", wd3, 32'hDEAD_BEEF);
        tick();
        chk("alu_we3_once", {31'd0, we3}, 32'd0);

        // Load extension table
        for (int i = 0; i < 10; i++) begin
            ld_req = 1'b1; ld_wa = 5'(i + 7);
            ld_size = vecs[i].size; ld_uns = vecs[i].uns; ld_off = vecs[i].off;
            tick();
            clear_inputs();
            chk("ld_busy", {31'd0, ld_busy}, 32'd1);
            chk("ld_rdy", {31'd0, ld_req_rdy}, 32'd0);
            ld_rvalid = 1'b1; ld_rdata = vecs[i].rdata;
            tick();
            clear_inputs();
            chk("ld_we3", {31'd0, we3}, 32'd1);
            chk("ld_wa3", {27'd0, wa3}, 32'(i + 7));
            chk("ld_wd3", wd3, vecs[i].exp);
            chk("ld_idle", {31'd0, ld_busy}, 32'd0);
        end

        // Collision: load and ALU in the same cycle
        ld_req = 1'b1; ld_wa = 5'd3; ld_size = 2'd2;
        tick();
        clear_inputs();
        ld_rvalid = 1'b1; ld_rdata = 32'h1122_3344;
        alu_vld = 1'b1; alu_wa = 5'd9; alu_wd = 32'h0000_0099;
        #1 chk("col_stall", {31'd0, alu_stall}, 32'd1);
        tick();
        ld_rvalid = 1'b0;
        chk("col_ld_wa3", {27'd0, wa3}, 32'd3);
        chk("col_ld_wd3", wd3, 32'h1122_3344);
        #1 chk("col_unstall", {31'd0, alu_stall}, 32'd0);
        tick();
        clear_inputs();
        chk("col_alu_we3", {31'd0, we3}, 32'd1);
        chk("col_alu_wa3", {27'd0, wa3}, 32'd9);
        chk("col_alu_wd3", wd3, 32'h0000_0099);

        // WAW: ALU to the pending load's destination waits
        ld_req = 1'b1; ld_wa = 5'd4; ld_size = 2'd2;
        tick();
        clear_inputs();
        alu_vld = 1'b1; alu_wa = 5'd4; alu_wd = 32'h0000_0044;
        #1 chk("waw_stall0", {31'd0, alu_stall}, 32'd1);
        tick();
        chk("waw_nowr", {31'd0, we3}, 32'd0);
        chk("waw_stall1", {31'd0, alu_stall}, 32'd1);
        ld_rvalid = 1'b1; ld_rdata = 32'h0000_0055;
        #1 chk("waw_stall2", {31'd0, alu_stall}, 32'd1);
        tick();
        ld_rvalid = 1'b0;
        chk("waw_ld_wa3", {27'd0, wa3}, 32'd4);
        chk("waw_ld_wd3", wd3, 32'h0000_0055);
        #1 chk("waw_unstall", {31'd0, alu_stall}, 32'd0);
        tick();
        clear_inputs();
        chk("waw_alu_we3", {31'd0, we3}, 32'd1);
        chk("waw_alu_wa3", {27'd0, wa3}, 32'd4);
        chk("waw_alu_wd3", wd3, 32'h0000_0044);

        // x0 write and spurious load data
        alu_vld = 1'b1; alu_wa = 5'd0; alu_wd = 32'h1234_5678;
        #1 chk("x0_stall", {31'd0, alu_stall}, 32'd0);
        tick();
        clear_inputs();
        chk("x0_we3", {31'd0, we3}, 32'd0);
        ld_rvalid = 1'b1; ld_rdata = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        chk("unexp_pulse", {31'd0, ld_unexp}, 32'd1);
        chk("unexp_we3", {31'd0, we3}, 32'd0);
        tick();
        chk("unexp_clear", {31'd0, ld_unexp}, 32'd0);

        // Reset while a load is outstanding
        ld_req = 1'b1; ld_wa = 5'd6;
        tick();
        clear_inputs();
        chk("rml_busy", {31'd0, ld_busy}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("rml_busy0", {31'd0, ld_busy}, 32'd0);
        chk("rml_we3", {31'd0, we3}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        ld_rvalid = 1'b1; ld_rdata = 32'h0000_00AA;
        tick();
        clear_inputs();
        chk("rml_unexp", {31'd0, ld_unexp}, 32'd1);
        chk("rml_nowr", {31'd0, we3}, 32'd0);
        tick();

        // Randomized traffic against the transaction model
        m_busy = 1'b0; m_wa = '0; m_size = 0; m_uns = 1'b0; m_off = 0;
        for (int c = 0; c < 3000; c++) begin
            alu_vld   = ($urandom_range(0, 99) < 60);
            alu_wa    = 5'($urandom_range(0, 7));
            alu_wd    = $urandom;
            ld_req    = ($urandom_range(0, 99) < 30);
            ld_wa     = 5'($urandom_range(0, 7));
            ld_size   = 2'($urandom_range(0, 2));
            ld_uns    = 1'($urandom_range(0, 1));
            ld_off    = 2'($urandom_range(0, 3));
            ld_rvalid = ($urandom_range(0, 99) < (m_busy ? 35 : 5));
            ld_rdata  = $urandom;

            e_stall = m_busy && alu_vld &&
                      (ld_rvalid || (alu_wa == m_wa && alu_wa != 5'd0));
            e_unexp = !m_busy && ld_rvalid;
            e_we = 1'b0; e_wa = '0; e_wd = '0;
            if (m_busy && ld_rvalid) begin
                e_we = (m_wa != 5'd0); e_wa = m_wa;
                e_wd = m_ext(m_size, m_uns, m_off, ld_rdata);
            end else if (alu_vld && !e_stall) begin
                e_we = (alu_wa != 5'd0); e_wa = alu_wa; e_wd = alu_wd;
            end
            if (m_busy && ld_rvalid) begin
                m_busy = 1'b0;
            end else if (!m_busy && ld_req) begin
                m_busy = 1'b1; m_wa = ld_wa; m_size = int'(ld_size);
                m_uns = ld_uns; m_off = int'(ld_off);
            end

            #1 chk("rnd_stall", {31'd0, alu_stall}, {31'd0, e_stall});
            tick();
            chk("rnd_we3", {31'd0, we3}, {31'd0, e_we});
            if (e_we) begin
                chk("rnd_wa3", {27'd0, wa3}, {27'd0, e_wa});
                chk("rnd_wd3", wd3, e_wd);
            end
            chk("rnd_unexp", {31'd0, ld_unexp}, {31'd0, e_unexp});
            chk("rnd_busy", {31'd0, ld_busy}, {31'd0, m_busy});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
